sync_fifo: RTL and testbench

Single-clock, first-word-fall-through (show-ahead) FIFO for byte-wide or wider data streams. The head entry is presented on `rd_data` whenever the FIFO is non-empty, and `rd_en` acknowledges and pops it. It is a generic buffering element between a producer and a consumer in the same clock domain, and needs no back-pressure logic beyond `full` and `empty`.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 75 +++++++
 tb/tb_sync_fifo.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared parameter defaults and elaboration helpers for the show-ahead FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Depth must be a power of two so the wrap-bit pointer scheme works.
  function automatic bit fifo_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array with synchronous write and asynchronous (show-ahead) read.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is always on rd_data
// while non-empty and rd_en pops it.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         wr_en,
  output logic                         full,
  output logic [WIDTH-1:0]             rd_data,
  input  logic                         rd_en,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic          wr_accept_c;
  logic          rd_accept_c;

  // Gating uses the pre-edge flags, so an empty FIFO never bypasses write to read.
  assign wr_accept_c = wr_en & ~full;
  assign rd_accept_c = rd_en & ~empty;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (wr_accept_c) begin
      wp_d = wp_q + PW'(1);
    end
    if (rd_accept_c) begin
      rp_d = rp_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Flags derive only from registered pointers; the MSB distinguishes full from empty.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign count = CW'(wp_q - rp_q);

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_accept_c),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (rp_q[AW-1:0]),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with a queue scoreboard of expected head words.
module tb_sync_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             full;
  logic [WIDTH-1:0] rd_data;
  logic             rd_en;
  logic             empty;
  logic [CW-1:0]    count;

  int unsigned vectors;
  int unsigned miscompares;
  logic [WIDTH-1:0] sb[$];

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .rd_data (rd_data),
    .rd_en   (rd_en),
    .empty   (empty),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags and head word against the scoreboard; called away from the rising edge.
  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(sb.size()));
    check({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    check({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
    if (sb.size() != 0) begin
      check({tag, ".head"}, 32'(rd_data), 32'(sb[0]));
    end
  endtask

  // One clock: drive at the falling edge, model the accepted ops, check at the next falling edge.
  task automatic cycle(input string tag, input logic we, input logic [WIDTH-1:0] wd, input logic re);
    bit wa, ra;
    wa = we && (sb.size() < DEPTH);
    ra = re && (sb.size() > 0);
    if (ra) begin
      check({tag, ".rd_data"}, 32'(rd_data), 32'(sb[0]));
    end
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    if (ra) void'(sb.pop_front());
    if (wa) sb.push_back(wd);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full",  32'(full),  32'd0);
    check("reset.count", 32'(count), 32'd0);
    reset = 1'b0;

    // First write falls through before any read.
    cycle("first_wr", 1'b1, 8'hA5, 1'b0);
    check("first_wr.head_a5", 32'(rd_data), 32'h0000_00A5);
    cycle("first_rd", 1'b0, 8'h00, 1'b1);

    // Two random bursts with a random reader, then drain; pointers pass DEPTH.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) begin
        cycle("burst", ~full, 8'($urandom), (~empty) & 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
        cycle("drain", 1'b0, 8'h00, 1'b1);
      end
      check("burst.drained", 32'(sb.size()), 32'd0);
    end

    // Fill, overflow attempt, ordered readout.
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill", 1'b1, 8'(i), 1'b0);
    end
    check("fill.full",  32'(full),  32'd1);
    check("fill.count", 32'(count), 32'd16);
    cycle("overflow", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("readout.value", 32'(rd_data), 32'(i));
      cycle("readout", 1'b0, 8'h00, 1'b1);
    end
    check("readout.empty", 32'(empty), 32'd1);

    // Reads while empty change nothing.
    for (int i = 0; i < 3; i++) begin
      cycle("empty_rd", 1'b0, 8'h00, 1'b1);
    end
    cycle("after_empty_wr", 1'b1, 8'h3C, 1'b0);
    cycle("after_empty_rd", 1'b0, 8'h00, 1'b1);

    // Simultaneous read/write at occupancy 5, then at full, then at empty.
    for (int i = 0; i < 5; i++) begin
      cycle("sim_pre", 1'b1, 8'(8'h40 + i), 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle("sim_rw", 1'b1, 8'(8'h80 + i), 1'b1);
    end
    check("sim_rw.count5", 32'(count), 32'd5);
    while (sb.size() < DEPTH) begin
      cycle("sim_fill", 1'b1, 8'($urandom), 1'b0);
    end
    cycle("sim_full_rw", 1'b1, 8'hEE, 1'b1);
    check("sim_full_rw.count15", 32'(count), 32'd15);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      cycle("sim_drain", 1'b0, 8'h00, 1'b1);
    end
    cycle("sim_empty_rw", 1'b1, 8'h77, 1'b1);
    check("sim_empty_rw.count1", 32'(count), 32'd1);
    cycle("sim_empty_pop", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset with 7 stored discards contents immediately.
    for (int i = 0; i < 7; i++) begin
      cycle("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0);
    end
    #2;
    reset = 1'b1;
    #1;
    check("midrst.empty", 32'(empty), 32'd1);
    check("midrst.count", 32'(count), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst_wr", 1'b1, 8'h5A, 1'b0);
    cycle("post_rst_rd", 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
